// File: rtl/pokey_poly_counter_pkg.sv
// -----------------------------------------------------------------------------
// pokey_pkg : POKEY polynomial lengths, tap positions and default configuration
// Revision  : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package pokey_pkg;

  // Poly lengths and their second feedback tap (1-based); first tap is the length
  localparam int POLY4_LEN  = 4;
  localparam int POLY4_TAP  = 3;
  localparam int POLY5_LEN  = 5;
  localparam int POLY5_TAP  = 3;
  localparam int POLY9_LEN  = 9;
  localparam int POLY9_TAP  = 5;
  localparam int POLY17_LEN = 17;
  localparam int POLY17_TAP = 12;

  localparam int DEFAULT_WIDTH     = POLY17_LEN;
  localparam int DEFAULT_TAP       = POLY17_TAP;
  localparam int DEFAULT_ALT_WIDTH = POLY9_LEN;
  localparam int DEFAULT_ALT_TAP   = POLY9_TAP;

endpackage : pokey_pkg

`default_nettype wire

// File: rtl/pokey_poly_counter_if.sv
// -----------------------------------------------------------------------------
// pokey_poly_counter_if : control and observation bundle for the poly counter
// Revision              : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface pokey_poly_counter_if
  import pokey_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             en;
  logic             init;
  logic             alt;
  logic             ld;
  logic [WIDTH-1:0] ld_data;
  logic             q;
  logic [7:0]       rnd;
  logic             wrap;
  logic [WIDTH-1:0] state;

  modport master (
    output en, init, alt, ld, ld_data,
    input  q, rnd, wrap, state
  );

  modport slave (
    input  en, init, alt, ld, ld_data,
    output q, rnd, wrap, state
  );
endinterface : pokey_poly_counter_if

`default_nettype wire

// File: rtl/pokey_poly_counter_poly_stage.sv
// -----------------------------------------------------------------------------
// poly_stage : one bit of the poly register with clear, load and step controls
// Revision   : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module poly_stage (
  input  wire logic clk_i,
  input  wire logic reset_i,
  input  wire logic en_i,
  input  wire logic init_i,
  input  wire logic ld_i,
  input  wire logic ld_bit_i,
  input  wire logic d_i,
  output logic      q_o
);
  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    if (init_i) begin
      bit_d = 1'b0;
    end else if (ld_i) begin
      bit_d = ld_bit_i;
    end else if (en_i) begin
      bit_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;
endmodule : poly_stage

`default_nettype wire

// File: rtl/pokey_poly_counter.sv
// -----------------------------------------------------------------------------
// pokey_poly_counter : XNOR LFSR noise counter with short-poly mode, parallel
//                      load, lock-up recovery and a period (wrap) marker
// Revision           : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pokey_poly_counter
  import pokey_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int TAP       = DEFAULT_TAP,
  parameter int ALT_WIDTH = DEFAULT_ALT_WIDTH,
  parameter int ALT_TAP   = DEFAULT_ALT_TAP
) (
  input  wire logic           clk_i,
  input  wire logic           reset_i,
  pokey_poly_counter_if.slave bus
);
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] shift_d;
  logic             msb;
  logic             tap;
  logic             lockup;
  logic             fb;
  logic             zero_next;
  logic             wrap_q;
  logic             wrap_d;

  // Only the active width feeds back; bits above it act as a delay chain
  always_comb begin
    msb       = s_q[WIDTH-1];
    tap       = s_q[TAP-1];
    lockup    = &s_q;
    if (bus.alt) begin
      msb    = s_q[ALT_WIDTH-1];
      tap    = s_q[ALT_TAP-1];
      lockup = &s_q[ALT_WIDTH-1:0];
    end
    fb        = lockup ? 1'b0 : ~(msb ^ tap);
    shift_d   = {s_q[WIDTH-2:0], fb};
    zero_next = bus.alt ? (shift_d[ALT_WIDTH-1:0] == '0) : (shift_d == '0);
    wrap_d    = bus.en & ~bus.init & ~bus.ld & zero_next;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    poly_stage u_stage (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .en_i     (bus.en),
      .init_i   (bus.init),
      .ld_i     (bus.ld),
      .ld_bit_i (bus.ld_data[i]),
      .d_i      (shift_d[i]),
      .q_o      (s_q[i])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  if (WIDTH >= 8) begin : g_rnd_full
    assign bus.rnd = s_q[7:0];
  end else begin : g_rnd_ext
    assign bus.rnd = {{(8-WIDTH){1'b0}}, s_q};
  end

  assign bus.q     = s_q[0];
  assign bus.wrap  = wrap_q;
  assign bus.state = s_q;
endmodule : pokey_poly_counter

`default_nettype wire

// File: tb/tb_pokey_poly_counter.sv
// -----------------------------------------------------------------------------
// tb_pokey_poly_counter : directed self-checking bench for pokey_poly_counter
// Revision              : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pokey_poly_counter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pokey_poly_counter_if #(.WIDTH(17)) bus ();

  pokey_poly_counter #(
    .WIDTH     (17),
    .TAP       (12),
    .ALT_WIDTH (9),
    .ALT_TAP   (5)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_steps(input int n);
    bus.en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic load(input logic [16:0] v);
    bus.ld_data = v;
    bus.ld      = 1'b1;
    @(posedge clk);
    #1;
    bus.ld      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 17'h0 || bus.q !== 1'b0 || bus.rnd !== 8'h00 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%h q=%b rnd=%h wrap=%b, want all zero",
               bus.state, bus.q, bus.rnd, bus.wrap);
    end
    reset = 1'b0;
  endtask

  task automatic test_long_seq();
    apply_reset();
    do_steps(11);
    checks++;
    if (bus.state !== 17'h007FF || bus.rnd !== 8'hFF) begin
      errors++;
      $display("FAIL long_11: state=%h rnd=%h, want 007ff ff", bus.state, bus.rnd);
    end
    do_steps(1);
    checks++;
    if (bus.state !== 17'h00FFF) begin
      errors++;
      $display("FAIL long_12: state=%h, want 00fff", bus.state);
    end
    do_steps(1);
    checks++;
    if (bus.state !== 17'h01FFE || bus.q !== 1'b0 || bus.rnd !== 8'hFE) begin
      errors++;
      $display("FAIL long_13: state=%h q=%b rnd=%h, want 01ffe 0 fe", bus.state, bus.q, bus.rnd);
    end
  endtask

  task automatic test_short_seq();
    int wraps;
    int wrap_at;
    apply_reset();
    bus.alt = 1'b1;
    do_steps(4);
    checks++;
    if (bus.state !== 17'h0000F) begin
      errors++;
      $display("FAIL short_4: state=%h, want 0000f", bus.state);
    end
    do_steps(1);
    checks++;
    if (bus.state !== 17'h0001F) begin
      errors++;
      $display("FAIL short_5: state=%h, want 0001f", bus.state);
    end
    do_steps(1);
    checks++;
    if (bus.state !== 17'h0003E || bus.rnd !== 8'h3E) begin
      errors++;
      $display("FAIL short_6: state=%h rnd=%h, want 0003e 3e", bus.state, bus.rnd);
    end
    apply_reset();
    wraps   = 0;
    wrap_at = 0;
    bus.en  = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      @(posedge clk);
      #1;
      if (bus.wrap === 1'b1) begin
        wraps++;
        wrap_at = i;
      end
    end
    bus.en = 1'b0;
    checks++;
    if (wraps !== 1 || wrap_at !== 511 || bus.state[8:0] !== 9'h000) begin
      errors++;
      $display("FAIL short_period: wraps=%0d at=%0d low9=%h, want 1 at 511 low9 000",
               wraps, wrap_at, bus.state[8:0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL short_wrap_width: wrap=%b, want 0", bus.wrap);
    end
    bus.alt = 1'b0;
  endtask

  task automatic test_lockup();
    logic [16:0] exp_s [4] = '{17'h1FFFE, 17'h1FFFD, 17'h1FFFB, 17'h1FFF7};
    apply_reset();
    load(17'h1FFFF);
    for (int i = 0; i < 4; i++) begin
      do_steps(1);
      checks++;
      if (bus.state !== exp_s[i]) begin
        errors++;
        $display("FAIL lockup_step%0d: state=%h, want %h", i, bus.state, exp_s[i]);
      end
    end
    bus.alt = 1'b1;
    load(17'h001FF);
    do_steps(1);
    checks++;
    if (bus.state !== 17'h003FE) begin
      errors++;
      $display("FAIL lockup_short: state=%h, want 003fe", bus.state);
    end
    bus.alt = 1'b0;
  endtask

  task automatic test_priority();
    apply_reset();
    do_steps(13);
    bus.init    = 1'b1;
    bus.ld      = 1'b1;
    bus.en      = 1'b1;
    bus.ld_data = 17'h00ABC;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 17'h0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL prio_init: state=%h wrap=%b, want 0 0", bus.state, bus.wrap);
    end
    bus.init = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 17'h00ABC || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL prio_ld: state=%h wrap=%b, want 00abc 0", bus.state, bus.wrap);
    end
    // Loading zero from the wrap predecessor must still not flag a wrap
    bus.ld_data = 17'h10000;
    @(posedge clk);
    #1;
    bus.ld_data = 17'h00000;
    @(posedge clk);
    #1;
    bus.ld = 1'b0;
    bus.en = 1'b0;
    checks++;
    if (bus.state !== 17'h0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL prio_ld_zero: state=%h wrap=%b, want 0 0", bus.state, bus.wrap);
    end
  endtask

  task automatic test_wrap_boundary();
    apply_reset();
    load(17'h10000);
    do_steps(1);
    checks++;
    if (bus.state !== 17'h0 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_long: state=%h wrap=%b, want 0 1", bus.state, bus.wrap);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_long_drop: wrap=%b, want 0", bus.wrap);
    end
    bus.alt = 1'b1;
    load(17'h10100);
    do_steps(1);
    checks++;
    if (bus.state !== 17'h00200 || bus.wrap !== 1'b1 || bus.rnd !== 8'h00) begin
      errors++;
      $display("FAIL wrap_short: state=%h wrap=%b rnd=%h, want 00200 1 00",
               bus.state, bus.wrap, bus.rnd);
    end
    bus.alt = 1'b0;
  endtask

  task automatic test_init_hold();
    apply_reset();
    do_steps(13);
    bus.init = 1'b1;
    bus.en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.state !== 17'h0 || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL init_hold%0d: state=%h wrap=%b, want 0 0", i, bus.state, bus.wrap);
      end
    end
    bus.init = 1'b0;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    checks++;
    if (bus.state !== 17'h00001 || bus.q !== 1'b1) begin
      errors++;
      $display("FAIL init_release: state=%h q=%b, want 00001 1", bus.state, bus.q);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_steps(13);
    bus.en = 1'b1;
    @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 17'h0 || bus.q !== 1'b0 || bus.rnd !== 8'h00 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%h q=%b rnd=%h wrap=%b, want all zero",
               bus.state, bus.q, bus.rnd, bus.wrap);
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    checks++;
    if (bus.state !== 17'h00001) begin
      errors++;
      $display("FAIL async_release: state=%h, want 00001", bus.state);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.init    = 1'b0;
    bus.alt     = 1'b0;
    bus.ld      = 1'b0;
    bus.ld_data = '0;
    test_reset();
    test_long_seq();
    test_short_seq();
    test_lockup();
    test_priority();
    test_wrap_boundary();
    test_init_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule : tb_pokey_poly_counter

`default_nettype wire
